// File: rtl/core_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// core_run_ctrl_if
//   Bundles the run-control signals shared by the host sequencer, the
//   processor core and core_run_ctrl. The controller connects through the
//   master modport; the host/core side of the testbench uses slave.
//
//   start       host -> ctrl   request to run the loaded program
//   ack         host -> ctrl   acknowledge of a finished or timed-out result
//   core_done   core -> ctrl   the core's done output
//   core_reset  ctrl -> core   drives the core's reset
//   core_req    ctrl -> core   drives the core's req
//   busy        ctrl -> host   high while the core is held in reset or running
//   finished    ctrl -> host   high once the program has completed
//   timed_out   ctrl -> host   high once the program was aborted by timeout
//   cycle_count ctrl -> host   number of RUN cycles, frozen after the run
// ---------------------------------------------------------------------------
interface core_run_ctrl_if #(
  parameter int CNT_W = 16
) ();

  logic             start;
  logic             ack;
  logic             core_done;
  logic             core_reset;
  logic             core_req;
  logic             busy;
  logic             finished;
  logic             timed_out;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    input  start,
    input  ack,
    input  core_done,
    output core_reset,
    output core_req,
    output busy,
    output finished,
    output timed_out,
    output cycle_count
  );

  modport slave (
    output start,
    output ack,
    output core_done,
    input  core_reset,
    input  core_req,
    input  busy,
    input  finished,
    input  timed_out,
    input  cycle_count
  );

endinterface

// File: rtl/core_run_ctrl.sv
// ---------------------------------------------------------------------------
// core_run_ctrl
//   Initiator side of the core's req/done run handshake. A host start holds
//   the core in reset for RST_CYCLES cycles, releases it with req raised,
//   counts RUN cycles until the core reports done, and aborts the run if it
//   exceeds TIMEOUT_CYCLES (0 disables the abort). All outputs are registered.
//
//   clk    system clock, rising edge
//   reset  asynchronous, active-high block reset
//   bus    core_run_ctrl_if.master: start/ack/core_done in,
//          core_reset/core_req/busy/finished/timed_out/cycle_count out
// ---------------------------------------------------------------------------
module core_run_ctrl #(
  parameter int CNT_W          = 16,
  parameter int RST_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4000
) (
  input  logic             clk,
  input  logic             reset,
  core_run_ctrl_if.master  bus
);

  localparam int               RST_W       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LAST    = RST_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_RUN,
    S_DONE,
    S_TOUT
  } state_t;

  state_t           r_state;
  logic [RST_W-1:0] r_rstCnt;
  logic             r_armed;
  logic [CNT_W-1:0] r_cycleCount;
  logic             r_coreReset;
  logic             r_coreReq;
  logic             r_busy;
  logic             r_finished;
  logic             r_timedOut;
  logic [CNT_W-1:0] w_countNext;

  // Saturating increment of the run counter; the timeout compare uses this
  // post-increment value so the abort lands on the TIMEOUT_CYCLES-th cycle.
  assign w_countNext = (r_cycleCount == {CNT_W{1'b1}}) ? r_cycleCount
                                                       : r_cycleCount + CNT_W'(1);

  // Run sequencer. Outputs are updated together with the state so each one
  // is a pure function of the state being entered.
  // armed only sets after done has been seen low once, so a done level left
  // over from a previous program cannot end the new run early.
  // In DONE the core is left out of reset so its memories stay inspectable;
  // in TOUT it is put back into reset to stop the hung program.
  // A start in DONE/TOUT restarts directly and takes priority over ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_rstCnt     <= '0;
      r_armed      <= 1'b0;
      r_cycleCount <= '0;
      r_coreReset  <= 1'b1;
      r_coreReq    <= 1'b0;
      r_busy       <= 1'b0;
      r_finished   <= 1'b0;
      r_timedOut   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state      <= S_RST;
            r_cycleCount <= '0;
            r_rstCnt     <= '0;
            r_armed      <= 1'b0;
            r_coreReset  <= 1'b1;
            r_busy       <= 1'b1;
          end
        end

        S_RST: begin
          r_rstCnt <= r_rstCnt + RST_W'(1);
          if (r_rstCnt == RST_LAST) begin
            r_state     <= S_RUN;
            r_coreReset <= 1'b0;
            r_coreReq   <= 1'b1;
          end
        end

        S_RUN: begin
          r_cycleCount <= w_countNext;
          if (!bus.core_done) begin
            r_armed <= 1'b1;
          end
          if (r_armed && bus.core_done) begin
            r_state    <= S_DONE;
            r_coreReq  <= 1'b0;
            r_busy     <= 1'b0;
            r_finished <= 1'b1;
          end else if (TIMEOUT_EN && (w_countNext == TIMEOUT_VAL)) begin
            r_state     <= S_TOUT;
            r_coreReq   <= 1'b0;
            r_coreReset <= 1'b1;
            r_busy      <= 1'b0;
            r_timedOut  <= 1'b1;
          end
        end

        S_DONE, S_TOUT: begin
          if (bus.start) begin
            r_state      <= S_RST;
            r_cycleCount <= '0;
            r_rstCnt     <= '0;
            r_armed      <= 1'b0;
            r_coreReset  <= 1'b1;
            r_busy       <= 1'b1;
            r_finished   <= 1'b0;
            r_timedOut   <= 1'b0;
          end else if (bus.ack) begin
            r_state     <= S_IDLE;
            r_coreReset <= 1'b1;
            r_finished  <= 1'b0;
            r_timedOut  <= 1'b0;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_coreReset <= 1'b1;
          r_coreReq   <= 1'b0;
          r_busy      <= 1'b0;
          r_finished  <= 1'b0;
          r_timedOut  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.core_reset  = r_coreReset;
  assign bus.core_req    = r_coreReq;
  assign bus.busy        = r_busy;
  assign bus.finished    = r_finished;
  assign bus.timed_out   = r_timedOut;
  assign bus.cycle_count = r_cycleCount;

endmodule

// File: tb/tb_core_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_core_run_ctrl
//   Drives core_run_ctrl with directed and randomized core_done waveforms and
//   compares its outputs against a reference computed from the run rules.
// ---------------------------------------------------------------------------
module tb_core_run_ctrl;

  localparam int CNT_W      = 16;
  localparam int RST_CYCLES = 2;
  localparam int TMO        = 20;

  logic clk;
  logic reset;

  core_run_ctrl_if #(.CNT_W(CNT_W)) bus ();

  core_run_ctrl #(
    .CNT_W(CNT_W),
    .RST_CYCLES(RST_CYCLES),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nCompared   = 0;
  int nMismatched = 0;
  int lastEnd     = 0;
  bit wave [1:TMO];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  // Outcome of a run for the current wave: the run ends at the first cycle
  // where done is high after having been low at some earlier RUN cycle;
  // without such a cycle within TMO cycles, it times out at TMO.
  task automatic refModel(output int endAt, output bit isDone);
    bit seenLow;
    seenLow = 1'b0;
    endAt   = TMO;
    isDone  = 1'b0;
    for (int n = 1; n <= TMO; n++) begin
      if (!isDone) begin
        if (wave[n] && seenLow) begin
          endAt  = n;
          isDone = 1'b1;
        end else if (!wave[n]) begin
          seenLow = 1'b1;
        end
      end
    end
  endtask

  task automatic genWave();
    int stale;
    stale = int'($urandom_range(0, 3));
    for (int n = 1; n <= TMO; n++) begin
      wave[n] = (n <= stale) ? 1'b1 : ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic clearWave();
    for (int n = 1; n <= TMO; n++) wave[n] = 1'b0;
  endtask

  task automatic checkIdle(input string tag, input int expCount);
    check({tag, ".busy"}, bus.busy, 0);
    check({tag, ".finished"}, bus.finished, 0);
    check({tag, ".timed_out"}, bus.timed_out, 0);
    check({tag, ".core_reset"}, bus.core_reset, 1);
    check({tag, ".core_req"}, bus.core_req, 0);
    check({tag, ".cycle_count"}, bus.cycle_count, expCount);
  endtask

  // One full program run from a start edge through the result state.
  task automatic applyStimulus(input bit alreadyStarted, input bit midStart, input int midAt);
    int endAt;
    bit isDone;
    refModel(endAt, isDone);
    if (!alreadyStarted) begin
      bus.start     = 1'b1;
      bus.core_done = wave[1];
      stepEdge();
      bus.start = 1'b0;
    end
    bus.core_done = wave[1];
    for (int r = 0; r < RST_CYCLES; r++) begin
      check("rst.core_reset", bus.core_reset, 1);
      check("rst.core_req", bus.core_req, 0);
      check("rst.busy", bus.busy, 1);
      check("rst.cycle_count", bus.cycle_count, 0);
      stepEdge();
    end
    for (int n = 1; n <= endAt; n++) begin
      check("run.core_req", bus.core_req, 1);
      check("run.core_reset", bus.core_reset, 0);
      check("run.busy", bus.busy, 1);
      check("run.finished", bus.finished, 0);
      check("run.cycle_count", bus.cycle_count, n - 1);
      bus.core_done = wave[n];
      bus.start     = midStart && (n == midAt);
      stepEdge();
      bus.start = 1'b0;
    end
    checkOutput(endAt, isDone);
    lastEnd = endAt;
    bus.core_done = 1'($urandom_range(0, 1));
    stepEdge();
    check("hold.cycle_count", bus.cycle_count, endAt);
    check("hold.finished", bus.finished, isDone);
    check("hold.timed_out", bus.timed_out, !isDone);
  endtask

  task automatic checkOutput(input int endAt, input bit isDone);
    check("end.finished", bus.finished, isDone);
    check("end.timed_out", bus.timed_out, !isDone);
    check("end.cycle_count", bus.cycle_count, endAt);
    check("end.core_req", bus.core_req, 0);
    check("end.core_reset", bus.core_reset, !isDone);
    check("end.busy", bus.busy, 0);
  endtask

  // Leave the result state: ack alone returns to IDLE, start+ack restarts.
  task automatic endRun(input bit withStart);
    bus.ack   = 1'b1;
    bus.start = withStart;
    stepEdge();
    bus.ack   = 1'b0;
    bus.start = 1'b0;
    if (!withStart) checkIdle("ack", lastEnd);
  endtask

  initial begin
    bit pending;
    bit midStart;
    int midAt;
    int endAt;
    bit isDone;

    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.ack       = 1'b0;
    bus.core_done = 1'b0;
    #2;
    checkIdle("reset", 0);
    #10;
    reset = 1'b0;
    stepEdge();
    checkIdle("idle", 0);

    $display("[TB] normal run, done at RUN cycle 10");
    clearWave();
    wave[10] = 1'b1;
    applyStimulus(1'b0, 1'b0, 0);
    endRun(1'b0);

    $display("[TB] stale done until RUN cycle 3, done at 7");
    clearWave();
    wave[1] = 1'b1;
    wave[2] = 1'b1;
    wave[7] = 1'b1;
    applyStimulus(1'b0, 1'b0, 0);
    endRun(1'b0);

    $display("[TB] timeout with done stuck low");
    clearWave();
    applyStimulus(1'b0, 1'b0, 0);
    endRun(1'b0);

    $display("[TB] done coincides with timeout");
    clearWave();
    wave[TMO] = 1'b1;
    applyStimulus(1'b0, 1'b0, 0);
    endRun(1'b0);

    $display("[TB] start during RUN, then start+ack in DONE");
    clearWave();
    wave[12] = 1'b1;
    applyStimulus(1'b0, 1'b1, 5);
    endRun(1'b1);
    pending = 1'b1;

    $display("[TB] randomized runs");
    for (int it = 0; it < 12; it++) begin
      genWave();
      refModel(endAt, isDone);
      midStart = (endAt > 2) && ($urandom_range(0, 1) == 1);
      midAt    = (endAt > 2) ? int'($urandom_range(1, endAt - 1)) : 0;
      applyStimulus(pending, midStart, midAt);
      pending = 1'($urandom_range(0, 1));
      endRun(pending);
    end
    if (pending) begin
      genWave();
      applyStimulus(1'b1, 1'b0, 0);
      endRun(1'b0);
    end

    $display("[TB] asynchronous reset in the middle of RUN");
    clearWave();
    bus.core_done = 1'b0;
    bus.start     = 1'b1;
    stepEdge();
    bus.start = 1'b0;
    repeat (RST_CYCLES + 4) stepEdge();
    check("mid.core_req", bus.core_req, 1);
    check("mid.cycle_count", bus.cycle_count, 4);
    #3;
    reset = 1'b1;
    #1;
    checkIdle("async", 0);
    #2;
    reset = 1'b0;
    stepEdge();
    checkIdle("after_reset", 0);

    $display("[TB] recovery run after reset");
    clearWave();
    wave[5] = 1'b1;
    applyStimulus(1'b0, 1'b0, 0);
    endRun(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
